// File: rtl/alu_dispatch.sv
// rtl/alu_dispatch.sv - requester-side ALU controller with two-pass redundant execute and compare
// Drives registered operands/ctrl into an external combinational ALU and returns result plus status.
module alu_dispatch #(
  parameter int WIDTH     = 32,
  parameter bit REDUNDANT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_taken,
  output logic             rsp_err,
  output logic             rsp_mismatch,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             fault_sticky,
  input  logic             fault_clr
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_BEQ = 3'b100;
  localparam logic [2:0] OP_BNE = 3'b101;

  typedef enum logic [1:0] {IDLE, EX1, EX2, RESP} state_t;

  state_t           state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] p1_result;
  logic             p1_zero;
  logic             pass_miss;
  logic             op_legal;

  function automatic logic [3:0] ctrl_of(input logic [2:0] op);
    case (op)
      OP_ADD:                 ctrl_of = 4'b0000;
      OP_SUB, OP_BEQ, OP_BNE: ctrl_of = 4'b0001;
      OP_AND:                 ctrl_of = 4'b0010;
      OP_OR:                  ctrl_of = 4'b0011;
      default:                ctrl_of = 4'b0000;
    endcase
  endfunction

  function automatic logic taken_of(input logic [2:0] op, input logic zero);
    case (op)
      OP_BEQ:  taken_of = zero;
      OP_BNE:  taken_of = ~zero;
      default: taken_of = 1'b0;
    endcase
  endfunction

  // Commutative ops re-run with swapped operands so pass 2 exercises different ALU input wiring.
  function automatic logic swap_of(input logic [2:0] op);
    swap_of = (op == OP_ADD) || (op == OP_AND) || (op == OP_OR);
  endfunction

  assign req_ready = (state == IDLE);
  assign op_legal  = (req_op[2:1] != 2'b11);
  assign pass_miss = ({p1_result, p1_zero} != {alu_result, alu_zero});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      op_q         <= 3'b000;
      p1_result    <= '0;
      p1_zero      <= 1'b0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_ctrl     <= 4'b0000;
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_taken    <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_mismatch <= 1'b0;
      fault_sticky <= 1'b0;
    end else begin
      // A set later in this block overrides the clear.
      if (fault_clr) fault_sticky <= 1'b0;

      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q <= req_op;
            if (op_legal) begin
              alu_a    <= req_a;
              alu_b    <= req_b;
              alu_ctrl <= ctrl_of(req_op);
              state    <= EX1;
            end else begin
              rsp_result   <= '0;
              rsp_zero     <= 1'b0;
              rsp_taken    <= 1'b0;
              rsp_err      <= 1'b1;
              rsp_mismatch <= 1'b0;
              rsp_valid    <= 1'b1;
              state        <= RESP;
            end
          end
        end

        EX1: begin
          p1_result <= alu_result;
          p1_zero   <= alu_zero;
          if (REDUNDANT) begin
            if (swap_of(op_q)) begin
              alu_a <= alu_b;
              alu_b <= alu_a;
            end
            state <= EX2;
          end else begin
            rsp_result   <= alu_result;
            rsp_zero     <= alu_zero;
            rsp_taken    <= taken_of(op_q, alu_zero);
            rsp_err      <= 1'b0;
            rsp_mismatch <= 1'b0;
            rsp_valid    <= 1'b1;
            state        <= RESP;
          end
        end

        EX2: begin
          rsp_result   <= p1_result;
          rsp_zero     <= p1_zero;
          rsp_taken    <= taken_of(op_q, p1_zero);
          rsp_err      <= 1'b0;
          rsp_mismatch <= pass_miss;
          if (pass_miss) fault_sticky <= 1'b1;
          rsp_valid    <= 1'b1;
          state        <= RESP;
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
